// File: rtl/tdc_frame_tx.sv
// Frames 48-bit TDC result words from the result FIFO into 8-byte serial frames:
// sync byte, six payload bytes MSB first, XOR checksum of the payload.
module tdc_frame_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FIFO_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [47:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] shift_q, shift_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  txd_q, txd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  byte_sel;
  logic        payload_byte;

  assign frame_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 2'd0;
      idx_q   <= 3'd0;
      shift_q <= 48'd0;
      csum_q  <= 8'd0;
      txd_q   <= 8'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      csum_q  <= csum_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
    end
  end

  // The payload shifts left after each payload byte, so the next one is always on top.
  always_comb begin
    payload_byte = (idx_q != 3'd0) && (idx_q != 3'd7);
    if (idx_q == 3'd0)      byte_sel = SYNC_BYTE;
    else if (idx_q == 3'd7) byte_sel = csum_q;
    else                    byte_sel = shift_q[47:40];
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    txd_d       = txd_q;
    cnt_d       = cnt_q;
    fifo_rd_en  = 1'b0;
    new_tx_data = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b0;
    tx_data     = txd_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        fifo_rd_en = 1'b1;
        busy       = 1'b1;
        wait_d     = 2'd1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_q == 2'(FIFO_LAT)) begin
          shift_d = fifo_dout;
          csum_d  = 8'd0;
          idx_d   = 3'd0;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_SEND: begin
        busy = 1'b1;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          tx_data     = byte_sel;
          txd_d       = byte_sel;
          if (payload_byte) begin
            csum_d  = csum_q ^ shift_q[47:40];
            shift_d = {shift_q[39:0], 8'd0};
          end
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Dead cycle: the transmitter only raises tx_busy the cycle after a strobe.
        if (idx_q == 3'd7) begin
          frame_done = 1'b1;
          cnt_d      = cnt_q + 16'd1;
          state_d    = S_IDLE;
        end else begin
          busy    = 1'b1;
          idx_d   = idx_q + 3'd1;
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tdc_frame_tx.sv
// Randomized bench for tdc_frame_tx: FIFO and transmitter models drive two instances
// (FIFO_LAT 1 and 2); a frame-level reference model predicts every strobed byte.
module tb_tdc_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, fifo_empty, fifo_rd_en, new_tx_data, tx_busy, busy, frame_done;
  logic [47:0] fifo_dout;
  logic [7:0]  tx_data;
  logic [15:0] frame_cnt;

  logic        enable2, fifo_empty2, fifo_rd_en2, new_tx_data2, tx_busy2, busy2, frame_done2;
  logic [47:0] fifo_dout2;
  logic [7:0]  tx_data2;
  logic [15:0] frame_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tdc_frame_tx #(.SYNC_BYTE(8'hA5), .FIFO_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  tdc_frame_tx #(.SYNC_BYTE(8'hA5), .FIFO_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_dout(fifo_dout2), .fifo_rd_en(fifo_rd_en2), .tx_data(tx_data2),
    .new_tx_data(new_tx_data2), .tx_busy(tx_busy2), .busy(busy2),
    .frame_done(frame_done2), .frame_cnt(frame_cnt2)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference frame: sync, six payload bytes MSB first, XOR of the payload bytes.
  function automatic logic [7:0] frame_byte(input logic [47:0] w, input int i);
    logic [7:0]  ck;
    logic [47:0] t;
    if (i == 0) return 8'hA5;
    if (i <= 6) begin
      t = w >> (8 * (6 - i));
      return t[7:0];
    end
    ck = 8'h00;
    for (int k = 0; k < 6; k++) begin
      t = w >> (8 * k);
      ck = ck ^ t[7:0];
    end
    return ck;
  endfunction

  // Instance 1 models
  logic [47:0] fifo1[$];
  logic [7:0]  expb[$];
  logic [47:0] pend;
  logic        have_next = 1'b0;
  logic [7:0]  last_byte = 8'h00;
  int          busy_mode = 0;
  int          busy_ct = 0;
  int          rd_cnt = 0, strobes = 0, in_frame = 0, frames = 0, rd_cyc = 0;
  logic        lat_chk = 1'b0;

  initial begin : mon1
    logic [47:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expb.delete();
        in_frame  = 0;
        frames    = 0;
        last_byte = 8'h00;
        have_next = 1'b0;
        busy_ct   = 0;
      end else begin
        if (fifo_rd_en || new_tx_data || frame_done)
          chk("one_strobe", 64'($countones({fifo_rd_en, new_tx_data, frame_done})), 1);
        if (fifo_rd_en) begin
          rd_cnt++;
          rd_cyc = cyc;
          chk("rd_busy", busy, 1);
          if (fifo1.size() == 0) chk("rd_empty_fifo", 1, 0);
          else begin
            w = fifo1.pop_front();
            pend = w;
            have_next = 1'b1;
            for (int i = 0; i < 8; i++) expb.push_back(frame_byte(w, i));
          end
        end
        if (new_tx_data) begin
          strobes++;
          in_frame++;
          chk("strobe_while_busy", tx_busy, 0);
          chk("busy_at_strobe", busy, 1);
          if (expb.size() == 0) chk("unexpected_byte", 1, 0);
          else chk("byte", tx_data, expb.pop_front());
          last_byte = tx_data;
          if (busy_mode == 1) busy_ct = 10;
        end else begin
          chk("tx_data_hold", tx_data, last_byte);
        end
        if (frame_done) begin
          chk("frame_len", in_frame, 8);
          in_frame = 0;
          chk("frame_cnt_pre", frame_cnt, 16'(frames));
          frames++;
          if (lat_chk) chk("latency_read_to_done", cyc - rd_cyc, 17);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    fifo_dout = have_next ? pend : {16'($urandom()), $urandom()};
    have_next = 1'b0;
    fifo_empty = (fifo1.size() == 0);
    case (busy_mode)
      1: begin
        tx_busy = (busy_ct > 0);
        if (busy_ct > 0) busy_ct--;
      end
      2: tx_busy = 1'($urandom_range(0, 1));
      default: tx_busy = 1'b0;
    endcase
  end

  // Instance 2 models (two-cycle FIFO read latency)
  logic [47:0] fifo2[$];
  logic [7:0]  expb2[$];
  logic [47:0] pend2, sa2;
  logic        have2 = 1'b0;
  int          frames2 = 0, b2cnt = 0;
  logic [7:0]  cs2_first = 8'hXX;

  initial begin : mon2
    logic [47:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expb2.delete();
        have2 = 1'b0;
      end else begin
        if (fifo_rd_en2) begin
          if (fifo2.size() == 0) chk("rd_empty_fifo2", 1, 0);
          else begin
            w = fifo2.pop_front();
            pend2 = w;
            have2 = 1'b1;
            for (int i = 0; i < 8; i++) expb2.push_back(frame_byte(w, i));
          end
        end
        if (new_tx_data2) begin
          b2cnt++;
          if (b2cnt == 8) cs2_first = tx_data2;
          if (expb2.size() == 0) chk("unexpected_byte2", 1, 0);
          else chk("byte_lat2", tx_data2, expb2.pop_front());
        end
        if (frame_done2) frames2++;
      end
    end
  end

  initial begin
    sa2 = '0;
    forever begin
      @(posedge clk);
      #1;
      fifo_dout2 = sa2;
      sa2 = have2 ? pend2 : {16'($urandom()), $urandom()};
      have2 = 1'b0;
      fifo_empty2 = (fifo2.size() == 0);
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (frames < target) chk("timeout_frames", 64'(frames), 64'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_new_tx"}, new_tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'h0000);
  endtask

  initial begin
    int r0, s0, n;
    rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; tx_busy2 = 1'b0;
    tx_busy = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Empty FIFO: nothing happens for 100 cycles.
    enable = 1'b1;
    r0 = rd_cnt; s0 = strobes;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_reads", 64'(rd_cnt - r0), 0);
    chk("idle_strobes", 64'(strobes - s0), 0);
    chk("idle_frame_cnt", frame_cnt, 0);

    // Single known word, transmitter always ready, latency checked.
    lat_chk = 1'b1;
    fifo1.push_back(48'h0123_4567_89AB);
    wait_frames(1, 200);
    lat_chk = 1'b0;
    chk("known_checksum", last_byte, 8'h22);
    @(posedge clk); #1;
    chk("frame_cnt_one", frame_cnt, 1);

    // Same word, transmitter busy for 10 cycles after each strobe.
    busy_mode = 1;
    fifo1.push_back(48'h0123_4567_89AB);
    wait_frames(2, 600);
    busy_mode = 0;

    // Three words queued, enable dropped during the second frame.
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) fifo1.push_back({16'($urandom()), $urandom()});
    r0 = rd_cnt;
    s0 = frames;
    enable = 1'b1;
    n = 0;
    while (rd_cnt < r0 + 2 && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    enable = 1'b0;
    wait_frames(s0 + 2, 200);
    repeat (60) @(posedge clk);
    #1;
    chk("enable_drop_reads", 64'(rd_cnt - r0), 2);
    chk("enable_drop_left", 64'(fifo1.size()), 1);
    fifo1.delete();

    // Asynchronous reset in the middle of byte idx 3.
    enable = 1'b1;
    fifo1.push_back({16'($urandom()), $urandom()});
    n = 0;
    while (in_frame < 4 && n < 200) begin @(negedge clk); #1; n++; end
    chk("reached_idx3", 64'(in_frame), 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fifo1.push_back(48'hDEAD_BEEF_0042);
    wait_frames(1, 200);
    @(posedge clk); #1;
    chk("frame_cnt_after_reset", frame_cnt, 1);

    // Random words with a randomly busy transmitter.
    busy_mode = 2;
    s0 = frames;
    for (int i = 0; i < 20; i++) fifo1.push_back({16'($urandom()), $urandom()});
    wait_frames(s0 + 20, 8000);
    busy_mode = 0;
    chk("random_leftover_bytes", 64'(expb.size()), 0);

    // Two-cycle FIFO latency instance.
    fifo2.push_back(48'hFFFF_FFFF_FFFF);
    fifo2.push_back(48'h0123_4567_89AB);
    fifo2.push_back({16'($urandom()), $urandom()});
    enable2 = 1'b1;
    n = 0;
    while (frames2 < 3 && n < 300) begin @(negedge clk); #1; n++; end
    chk("lat2_frames", 64'(frames2), 3);
    chk("lat2_ff_checksum", cs2_first, 8'h00);
    chk("lat2_leftover_bytes", 64'(expb2.size()), 0);
    @(posedge clk); #1;
    chk("lat2_frame_cnt", frame_cnt2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
